// File: rtl/result_display_pkg.sv
// Shared types and constants for the result_display seven-segment driver.
// Optional build macro: RESULT_DISPLAY_LZ_BLANK_EN (leading-zero blanking).
package result_display_pkg;

    typedef logic [1:0] digit_idx_t;

    localparam digit_idx_t DIGIT_FIRST = 2'd0;
    localparam digit_idx_t DIGIT_LAST  = 2'd3;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    // Active-low {g,f,e,d,c,b,a}; entry [n] encodes hex digit n.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46,
        7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19,
        7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] hex_seg(input logic [3:0] nib);
        return SEG_LUT[nib];
    endfunction

endpackage

// File: rtl/result_display_hex7seg.sv
// Combinational hex nibble to active-low seven-segment encoder.
// Optional build macro: none.
module hex7seg
    import result_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = hex_seg(nibble);
    end

endmodule

// File: rtl/result_display.sv
// Tear-free 4-digit hex display driver with shadow/commit at frame ends.
// Optional build macro: RESULT_DISPLAY_LZ_BLANK_EN (leading-zero blanking, hold dp).
module result_display
    import result_display_pkg::*;
#(
    parameter int DATA_W      = 15,
    parameter int REFRESH_DIV = 100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] value,
    input  logic              sample_en,
    input  logic              hold,
    output logic [6:0]        seg,
    output logic [3:0]        an,
    output logic              dp,
    output logic              frame_done
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);

    logic [PW-1:0] prescaler_q, prescaler_d;
    digit_idx_t    digit_idx_q, digit_idx_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [15:0]   disp_q, disp_d;
    logic          frame_done_q, frame_done_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic          dp_q, dp_d;

    logic          tick;
    logic          frame_end;
    logic [15:0]   value_ext;
    logic [3:0]    nibble;
    logic [6:0]    nib_seg;

    always_comb begin
        value_ext = '0;
        value_ext[DATA_W-1:0] = value;
    end

    // A commit reads shadow_q, so a same-edge capture lands next frame.
    always_comb begin
        tick         = (prescaler_q == PRE_MAX);
        frame_end    = tick && (digit_idx_q == DIGIT_LAST);
        prescaler_d  = tick ? '0 : prescaler_q + 1'b1;
        digit_idx_d  = tick ? digit_idx_q + 1'b1 : digit_idx_q;
        shadow_d     = (sample_en && !hold) ? value_ext : shadow_q;
        disp_d       = frame_end ? shadow_q : disp_q;
        frame_done_d = frame_end;
    end

    assign nibble = disp_q[{digit_idx_q, 2'b00} +: 4];

    hex7seg u_hex7seg (
        .nibble (nibble),
        .seg    (nib_seg)
    );

`ifdef RESULT_DISPLAY_LZ_BLANK_EN
    logic blank;

    always_comb begin
        blank = (digit_idx_q != DIGIT_FIRST) &&
                ((disp_q >> {digit_idx_q, 2'b00}) == 16'h0000);
        an_d  = ~(4'b0001 << digit_idx_q);
        seg_d = blank ? SEG_BLANK : nib_seg;
        dp_d  = !((digit_idx_q == DIGIT_FIRST) && hold);
    end
`else
    always_comb begin
        an_d  = ~(4'b0001 << digit_idx_q);
        seg_d = nib_seg;
        dp_d  = 1'b1;
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            prescaler_q  <= '0;
            digit_idx_q  <= DIGIT_FIRST;
            shadow_q     <= '0;
            disp_q       <= '0;
            frame_done_q <= 1'b0;
            seg_q        <= SEG_BLANK;
            an_q         <= AN_OFF;
            dp_q         <= 1'b1;
        end else begin
            prescaler_q  <= prescaler_d;
            digit_idx_q  <= digit_idx_d;
            shadow_q     <= shadow_d;
            disp_q       <= disp_d;
            frame_done_q <= frame_done_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            dp_q         <= dp_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_result_display.sv
// Randomized bench for result_display against a cycle-count reference model.
// Optional build macro: RESULT_DISPLAY_LZ_BLANK_EN changes expected blanking/dp.
module tb_result_display;

    localparam int DW = 15;
    localparam int RD = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] value;
    logic          sample_en;
    logic          hold;
    logic [6:0]    seg;
    logic [3:0]    an;
    logic          dp;
    logic          frame_done;

    int checks = 0;
    int errors = 0;

    // Model state: edges since reset release, pending and shown values.
    int m_cnt    = 0;
    int m_shadow = 0;
    int m_disp   = 0;
    bit last_fend = 1'b0;

    logic [6:0] seg_ref [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    result_display #(
        .DATA_W      (DW),
        .REFRESH_DIV (RD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .value      (value),
        .sample_en  (sample_en),
        .hold       (hold),
        .seg        (seg),
        .an         (an),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit next_is_fend();
        return reset && ((m_cnt % RD) == RD - 1) && (((m_cnt / RD) % 4) == 3);
    endfunction

    task automatic step();
        int idx;
        int nib;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        logic       e_fd;
        if (!reset) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
            m_cnt = 0; m_shadow = 0; m_disp = 0; last_fend = 1'b0;
        end else begin
            idx   = (m_cnt / RD) % 4;
            nib   = (m_disp >> (4 * idx)) & 15;
            e_an  = ~(4'b0001 << idx);
            e_seg = seg_ref[nib];
            e_dp  = 1'b1;
`ifdef RESULT_DISPLAY_LZ_BLANK_EN
            if (idx != 0 && (m_disp >> (4 * idx)) == 0) e_seg = 7'h7F;
            if (idx == 0 && hold) e_dp = 1'b0;
`endif
            e_fd = next_is_fend();
            last_fend = e_fd;
            if (e_fd) m_disp = m_shadow;
            if (sample_en && !hold) m_shadow = int'(value);
            m_cnt++;
        end
        @(posedge clk);
        #1;
        check("an", 32'(an), 32'(e_an));
        check("seg", 32'(seg), 32'(e_seg));
        check("dp", 32'(dp), 32'(e_dp));
        check("frame_done", 32'(frame_done), 32'(e_fd));
    endtask

    task automatic wait_fend(input string tag);
        for (int i = 0; i < 40; i++) begin
            step();
            if (last_fend) return;
        end
        check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic pulse(input logic [DW-1:0] v);
        value = v;
        sample_en = 1'b1;
        step();
        sample_en = 1'b0;
    endtask

    // Starts right after a frame-end edge; ends on the next frame-end edge.
    task automatic check_frame(input string tag, input logic [6:0] e0,
                               input logic [6:0] e1, input logic [6:0] e2,
                               input logic [6:0] e3);
        logic [6:0] exp_s [4];
        logic [3:0] exp_a;
        exp_s = '{e0, e1, e2, e3};
        for (int d = 0; d < 4; d++) begin
            step();
            exp_a = ~(4'b0001 << d);
            check({tag, "_an"}, 32'(an), 32'(exp_a));
            check({tag, "_seg"}, 32'(seg), 32'(exp_s[d]));
            for (int k = 1; k < RD; k++) step();
        end
        check({tag, "_fend"}, 32'(last_fend), 1);
    endtask

    initial begin
        int fd_cnt;
        reset = 1'b0; value = '0; sample_en = 1'b0; hold = 1'b0;

        for (int i = 0; i < 3; i++) step();
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(seg), 32'h7F);
        reset = 1'b1;
        step();
        check("rel_an", 32'(an), 32'hE);

        pulse(15'h1A2F);
        wait_fend("cap");
        check_frame("cap", 7'h0E, 7'h24, 7'h08, 7'h79);

        fd_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (frame_done) fd_cnt++;
        end
        check("fd_rate", fd_cnt, 4);

        pulse(15'h0005);
        wait_fend("h0");
        hold = 1'b1;
        pulse(15'h7FFF);
        wait_fend("h1");
`ifdef RESULT_DISPLAY_LZ_BLANK_EN
        check_frame("held", 7'h12, 7'h7F, 7'h7F, 7'h7F);
`else
        check_frame("held", 7'h12, 7'h40, 7'h40, 7'h40);
`endif
        hold = 1'b0;
        pulse(15'h7FFF);
        wait_fend("h2");
        check_frame("unheld", 7'h0E, 7'h0E, 7'h0E, 7'h78);

        pulse(15'h0456);
        for (int i = 0; i < 40 && !next_is_fend(); i++) step();
        pulse(15'h0123);
        check("coll_fend", 32'(last_fend), 1);
`ifdef RESULT_DISPLAY_LZ_BLANK_EN
        check_frame("coll_old", 7'h02, 7'h12, 7'h19, 7'h7F);
        check_frame("coll_new", 7'h30, 7'h24, 7'h79, 7'h7F);
`else
        check_frame("coll_old", 7'h02, 7'h12, 7'h19, 7'h40);
        check_frame("coll_new", 7'h30, 7'h24, 7'h79, 7'h40);
`endif

        pulse(15'h3333);
        for (int i = 0; i < 40 && ((m_cnt / RD) % 4) != 2; i++) step();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        wait_fend("mr");
`ifdef RESULT_DISPLAY_LZ_BLANK_EN
        check_frame("midrst", 7'h40, 7'h7F, 7'h7F, 7'h7F);
`else
        check_frame("midrst", 7'h40, 7'h40, 7'h40, 7'h40);
`endif

        pulse(15'h0040);
        wait_fend("lz");
`ifdef RESULT_DISPLAY_LZ_BLANK_EN
        check_frame("lz", 7'h40, 7'h19, 7'h7F, 7'h7F);
`else
        check_frame("lz", 7'h40, 7'h19, 7'h40, 7'h40);
`endif
        hold = 1'b1;
        step();
`ifdef RESULT_DISPLAY_LZ_BLANK_EN
        check("hold_dp", 32'(dp), 0);
`else
        check("hold_dp", 32'(dp), 1);
`endif
        hold = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            value     = DW'($urandom_range(0, (1 << DW) - 1));
            sample_en = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) hold = ~hold;
            reset     = ($urandom_range(0, 299) != 0);
            step();
        end
        reset = 1'b1;
        sample_en = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
